// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - ADC, FFT RAM, engine handshake and magnitude stream bundle
interface fft_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                    i_frame_req;
  logic [DATA_WIDTH-1:0]   i_adc_data;
  logic                    i_adc_valid;
  logic                    o_ld_wen;
  logic [ADDR_WIDTH-1:0]   o_ld_waddr;
  logic [2*DATA_WIDTH-1:0] o_ld_wdata;
  logic                    o_ram_sel;
  logic                    o_fft_start;
  logic                    i_fft_done;
  logic                    o_rd_ren;
  logic [ADDR_WIDTH-1:0]   o_rd_raddr;
  logic [2*DATA_WIDTH-1:0] i_rd_rdata;
  logic [DATA_WIDTH:0]     o_mag_data;
  logic                    o_mag_valid;
  logic [ADDR_WIDTH-1:0]   o_mag_index;
  logic                    o_mag_last;
  logic                    o_busy;
  logic                    o_fft_err;

  modport slave (
    input  i_frame_req, i_adc_data, i_adc_valid, i_fft_done, i_rd_rdata,
    output o_ld_wen, o_ld_waddr, o_ld_wdata, o_ram_sel, o_fft_start,
           o_rd_ren, o_rd_raddr, o_mag_data, o_mag_valid, o_mag_index,
           o_mag_last, o_busy, o_fft_err
  );

  modport master (
    output i_frame_req, i_adc_data, i_adc_valid, i_fft_done, i_rd_rdata,
    input  o_ld_wen, o_ld_waddr, o_ld_wdata, o_ram_sel, o_fft_start,
           o_rd_ren, o_rd_raddr, o_mag_data, o_mag_valid, o_mag_index,
           o_mag_last, o_busy, o_fft_err
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - capture a bit-reversed frame, hand RAM to the FFT, stream |re|+|im|
module fft_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int OUT_HALF   = 1,
  parameter int TIMEOUT    = 4096
) (
  input logic             clk,
  input logic             rst_n,
  fft_frame_ctrl_if.slave bus
);
  localparam int N       = 1 << ADDR_WIDTH;
  localparam int OUT_LEN = (OUT_HALF != 0) ? (N / 2) : N;
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(OUT_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]       WD_ONE   = WD_W'(1);
  localparam logic [DATA_WIDTH:0]   MAG_ONE  = (DATA_WIDTH + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_UNLOAD, S_DRAIN} state_t;

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH:0]     r_ld_cnt;
  logic                    r_ld_wen;
  logic [ADDR_WIDTH-1:0]   r_ld_waddr;
  logic [2*DATA_WIDTH-1:0] r_ld_wdata;
  logic [WD_W-1:0]         r_wd;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [ADDR_WIDTH-1:0]   r_rd_idx;
  logic                    r_rd_v;
  logic [DATA_WIDTH:0]     r_mag_data;
  logic                    r_mag_valid;
  logic [ADDR_WIDTH-1:0]   r_mag_index;
  logic                    r_mag_last;
  logic                    w_ld_accept;
  logic                    w_timeout;
  logic [DATA_WIDTH:0]     w_mag;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = v[ADDR_WIDTH-1-i];
    return r;
  endfunction

  // Widen before negating so the most negative sample maps to +2^(DATA_WIDTH-1).
  function automatic logic [DATA_WIDTH:0] abs_ext(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH:0] e;
    e = {v[DATA_WIDTH-1], v};
    return v[DATA_WIDTH-1] ? (~e + MAG_ONE) : e;
  endfunction

  assign w_ld_accept = (r_state == S_LOAD) && bus.i_adc_valid && !r_ld_cnt[ADDR_WIDTH];
  assign w_mag = abs_ext(bus.i_rd_rdata[DATA_WIDTH-1:0]) + abs_ext(bus.i_rd_rdata[2*DATA_WIDTH-1:DATA_WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.i_frame_req) w_next = S_LOAD;
      // Leave once the N-th write is on the RAM port, so fft_start trails it by one cycle.
      S_LOAD:   if (r_ld_wen && r_ld_cnt[ADDR_WIDTH]) w_next = S_START;
      S_START:  w_next = S_RUN;
      S_RUN: begin
        if (bus.i_fft_done) begin
          w_next = S_UNLOAD;
        end else if (r_wd == WD_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_UNLOAD: if (r_rd_addr == LAST_BIN) w_next = S_DRAIN;
      S_DRAIN:  if (r_mag_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt   <= '0;
      r_ld_wen   <= 1'b0;
      r_ld_waddr <= '0;
      r_ld_wdata <= '0;
    end else begin
      r_ld_wen <= w_ld_accept;
      if (r_state == S_IDLE) begin
        r_ld_cnt <= '0;
      end else if (w_ld_accept) begin
        r_ld_cnt   <= r_ld_cnt + CNT_ONE;
        r_ld_waddr <= bitrev(r_ld_cnt[ADDR_WIDTH-1:0]);
        r_ld_wdata <= {{DATA_WIDTH{1'b0}}, bus.i_adc_data};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_rd_addr <= '0;
      r_rd_idx  <= '0;
      r_rd_v    <= 1'b0;
    end else begin
      r_wd      <= (r_state == S_RUN) ? r_wd + WD_ONE : '0;
      r_rd_addr <= (r_state == S_UNLOAD) ? r_rd_addr + ADDR_ONE : '0;
      r_rd_idx  <= r_rd_addr;
      r_rd_v    <= (r_state == S_UNLOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_data  <= '0;
      r_mag_valid <= 1'b0;
      r_mag_index <= '0;
      r_mag_last  <= 1'b0;
    end else begin
      r_mag_valid <= r_rd_v;
      r_mag_last  <= r_rd_v && (r_rd_idx == LAST_BIN);
      if (r_rd_v) begin
        r_mag_data  <= w_mag;
        r_mag_index <= r_rd_idx;
      end
    end
  end

  assign bus.o_ld_wen    = r_ld_wen;
  assign bus.o_ld_waddr  = r_ld_waddr;
  assign bus.o_ld_wdata  = r_ld_wdata;
  assign bus.o_ram_sel   = (r_state == S_START) || (r_state == S_RUN);
  assign bus.o_fft_start = (r_state == S_START);
  assign bus.o_rd_ren    = (r_state == S_UNLOAD);
  assign bus.o_rd_raddr  = r_rd_addr;
  assign bus.o_mag_data  = r_mag_data;
  assign bus.o_mag_valid = r_mag_valid;
  assign bus.o_mag_index = r_mag_index;
  assign bus.o_mag_last  = r_mag_last;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_fft_err   = w_timeout;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed vector bench for fft_frame_ctrl with a RAM/engine model
module tb_fft_frame_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  fft_frame_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_HALF(1), .TIMEOUT(4096))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [DW-1:0] re; logic [DW-1:0] im; logic [DW:0] mag; } mag_vec_t;
  typedef struct { int idx; logic [AW-1:0] addr; } addr_vec_t;
  mag_vec_t  mag_tbl  [8];
  addr_vec_t addr_tbl [8];

  logic [2*DW-1:0] mem [1<<AW];
  logic            eng_we   = 1'b0;
  logic [AW-1:0]   eng_addr = '0;
  logic [2*DW-1:0] eng_data = '0;
  int unsigned     cyc_cnt  = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bus.o_ld_wen) mem[bus.o_ld_waddr] <= bus.o_ld_wdata;
    else if (eng_we)  mem[eng_addr] <= eng_data;
    if (bus.o_rd_ren) bus.i_rd_rdata <= mem[bus.o_rd_raddr];
  end

  logic [AW-1:0]   wr_addr_q [$];
  logic [2*DW-1:0] wr_data_q [$];
  int unsigned     wr_cyc_q  [$];
  logic [DW:0]     mag_data_q [$];
  logic [AW-1:0]   mag_idx_q  [$];
  logic            mag_last_q [$];
  int unsigned     mag_cyc_q  [$];
  int unsigned     n_start = 0, n_err = 0, n_conflict = 0, busy_fall_cyc = 0;
  logic            prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.o_ld_wen) begin
      wr_addr_q.push_back(bus.o_ld_waddr);
      wr_data_q.push_back(bus.o_ld_wdata);
      wr_cyc_q.push_back(cyc_cnt);
    end
    if (bus.o_mag_valid) begin
      mag_data_q.push_back(bus.o_mag_data);
      mag_idx_q.push_back(bus.o_mag_index);
      mag_last_q.push_back(bus.o_mag_last);
      mag_cyc_q.push_back(cyc_cnt);
    end
    if (bus.o_fft_start) n_start <= n_start + 1;
    if (bus.o_fft_err)   n_err <= n_err + 1;
    if (bus.o_ram_sel && (bus.o_ld_wen || bus.o_rd_ren)) n_conflict <= n_conflict + 1;
    if (prev_busy && !bus.o_busy) busy_fall_cyc <= cyc_cnt;
    prev_busy <= bus.o_busy;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [7:0] br8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic request();
    bus.i_frame_req = 1'b1;
    cyc();
    bus.i_frame_req = 1'b0;
  endtask

  task automatic load_frame(input int n, input int gap, input logic [DW-1:0] xorv, input bit poke);
    for (int k = 0; k < n; k++) begin
      bus.i_adc_valid = 1'b1;
      bus.i_adc_data  = DW'(k) ^ xorv;
      cyc();
      bus.i_adc_valid = 1'b0;
      if (k != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (poke && k == 50) begin
            bus.i_frame_req = 1'b1;
            bus.i_fft_done  = 1'b1;
          end
          cyc();
          bus.i_frame_req = 1'b0;
          bus.i_fft_done  = 1'b0;
        end
      end
    end
  endtask

  // Waits for fft_start and checks the frame's write log; returns at the START cycle.
  task automatic frame_start(input int wb, input logic [DW-1:0] xorv, input int gap, input string tag);
    int bad;
    int nw;
    for (int i = 0; i < 20 && !bus.o_fft_start; i++) cyc();
    check({tag, "_start_seen"}, bus.o_fft_start, 1);
    check({tag, "_ram_sel_rise"}, bus.o_ram_sel, 1);
    nw = wr_addr_q.size() - wb;
    check({tag, "_write_count"}, nw, 256);
    if (nw == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wr_addr_q[wb+i] != br8(8'(i))) bad++;
        if (wr_data_q[wb+i] != {16'h0000, 16'(i) ^ xorv}) bad++;
        if (i > 0 && wr_cyc_q[wb+i] - wr_cyc_q[wb+i-1] != gap + 1) bad++;
      end
      check({tag, "_write_seq"}, bad, 0);
      for (int i = 0; i < 8; i++)
        check($sformatf("%s_addr_vec%0d", tag, i), wr_addr_q[wb+addr_tbl[i].idx], addr_tbl[i].addr);
      check({tag, "_start_latency"}, cyc_cnt - wr_cyc_q[wb+255], 1);
    end
  endtask

  initial begin
    int wb, mb, sb, eb, k, bad;
    mag_tbl[0] = '{16'h0003, 16'hFFFB, 17'd8};
    mag_tbl[1] = '{16'h8000, 16'h8000, 17'd65536};
    mag_tbl[2] = '{16'h7FFF, 16'h7FFF, 17'd65534};
    mag_tbl[3] = '{16'hFFFF, 16'h0001, 17'd2};
    mag_tbl[4] = '{16'h0000, 16'h0000, 17'd0};
    mag_tbl[5] = '{16'h8000, 16'h7FFF, 17'd65535};
    mag_tbl[6] = '{16'h0064, 16'hFF38, 17'd300};
    mag_tbl[7] = '{16'hCFC7, 16'h0000, 17'd12345};
    addr_tbl[0] = '{0, 8'd0};
    addr_tbl[1] = '{1, 8'd128};
    addr_tbl[2] = '{2, 8'd64};
    addr_tbl[3] = '{3, 8'd192};
    addr_tbl[4] = '{4, 8'd32};
    addr_tbl[5] = '{5, 8'd160};
    addr_tbl[6] = '{12, 8'd48};
    addr_tbl[7] = '{255, 8'd255};

    bus.i_frame_req = 1'b0;
    bus.i_adc_data  = '0;
    bus.i_adc_valid = 1'b0;
    bus.i_fft_done  = 1'b0;

    repeat (3) cyc();
    check("reset_ld", {bus.o_ld_wen, bus.o_ld_waddr, bus.o_ld_wdata}, 0);
    check("reset_ctl", {bus.o_ram_sel, bus.o_fft_start, bus.o_rd_ren, bus.o_rd_raddr, bus.o_fft_err}, 0);
    check("reset_mag", {bus.o_mag_data, bus.o_mag_valid, bus.o_mag_index, bus.o_mag_last}, 0);
    check("reset_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    cyc();
    check("idle_busy", bus.o_busy, 0);

    // Frame 1: continuous ramp, engine overwrites bins 0..7, done after ~1000 RUN cycles
    sb = n_start; wb = wr_addr_q.size(); mb = mag_data_q.size();
    request();
    check("f1_busy_load", bus.o_busy, 1);
    load_frame(256, 0, 16'h0000, 1'b0);
    frame_start(wb, 16'h0000, 0, "f1");
    for (int i = 0; i < 8; i++) begin
      eng_we = 1'b1; eng_addr = 8'(i); eng_data = {mag_tbl[i].im, mag_tbl[i].re};
      cyc();
    end
    eng_we = 1'b0;
    repeat (992) cyc();
    check("f1_ram_sel_run", bus.o_ram_sel, 1);
    bus.i_fft_done = 1'b1;
    cyc();
    bus.i_fft_done = 1'b0;
    check("f1_ram_sel_fall", bus.o_ram_sel, 0);
    check("f1_unload_first", {bus.o_rd_ren, bus.o_rd_raddr}, {1'b1, 8'd0});
    for (int i = 0; i < 400 && bus.o_busy; i++) cyc();
    check("f1_busy_drop", bus.o_busy, 0);
    repeat (2) cyc();
    check("f1_start_pulses", n_start - sb, 1);
    check("f1_mag_count", mag_data_q.size() - mb, 128);
    if (mag_data_q.size() - mb == 128) begin
      for (int i = 0; i < 8; i++)
        check($sformatf("mag_vec%0d", i), mag_data_q[mb+i], mag_tbl[i].mag);
      bad = 0;
      for (int a = 0; a < 128; a++) begin
        if (mag_idx_q[mb+a] != 8'(a)) bad++;
        if (a >= 8 && mag_data_q[mb+a] != {9'd0, br8(8'(a))}) bad++;
        if (mag_last_q[mb+a] != (a == 127)) bad++;
      end
      check("f1_mag_stream", bad, 0);
      check("f1_last_index", {mag_last_q[mb+127], mag_idx_q[mb+127]}, {1'b1, 8'd127});
      check("f1_consecutive", mag_cyc_q[mb+127] - mag_cyc_q[mb], 127);
      check("f1_busy_fall", busy_fall_cyc, mag_cyc_q[mb+127] + 1);
    end

    // Frame 2: gapped load with stray frame_req/fft_done, then watchdog timeout
    sb = n_start; wb = wr_addr_q.size(); eb = n_err;
    request();
    load_frame(256, 2, 16'h5A00, 1'b1);
    frame_start(wb, 16'h5A00, 2, "f2");
    k = 0;
    do begin cyc(); k++; end while (!bus.o_fft_err && k < 5000);
    check("f2_timeout_cycle", k, 4096);
    cyc();
    check("f2_after_err", {bus.o_ram_sel, bus.o_busy, bus.o_fft_err}, 0);
    repeat (2) cyc();
    check("f2_err_pulses", n_err - eb, 1);
    check("f2_start_pulses", n_start - sb, 1);

    // Frame 3: fresh load after timeout, then reset in the middle of UNLOAD
    wb = wr_addr_q.size();
    request();
    load_frame(256, 0, 16'h0000, 1'b0);
    frame_start(wb, 16'h0000, 0, "f3");
    repeat (10) cyc();
    bus.i_fft_done = 1'b1;
    cyc();
    bus.i_fft_done = 1'b0;
    repeat (5) cyc();
    check("f3_streaming", {bus.o_mag_valid, bus.o_rd_ren}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("f3_reset_abort", {bus.o_mag_valid, bus.o_rd_ren, bus.o_busy, bus.o_ram_sel}, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Frame 4: partial frame discarded by reset, next frame starts from sample 0
    request();
    load_frame(100, 0, 16'h1111, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("f4_idle_after_reset", bus.o_busy, 0);
    sb = n_start; wb = wr_addr_q.size();
    request();
    load_frame(256, 0, 16'h2222, 1'b0);
    frame_start(wb, 16'h2222, 0, "f4");
    repeat (3) cyc();
    check("f4_start_pulses", n_start - sb, 1);
    check("bus_conflicts", n_conflict, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame controller on the far side of the oscilloscope FFT RAM. It captures one frame of ADC samples into the shared complex RAM in bit-reversed order, then hands the RAM to the in-place radix-2 FFT engine with a start pulse. After the engine reports done, it reads the natural-order spectrum back and streams |re|+|im| magnitudes to the display/spectrum path.

## Interface
- DATA_WIDTH, 16, signed sample / real / imag width; RAM word = {imag, real} = 2*DATA_WIDTH.
- ADDR_WIDTH, 8, RAM address width; frame length N = 2^ADDR_WIDTH.
- OUT_HALF, 1, 1 = unload bins 0..N/2-1 only; 0 = unload all N bins.
- TIMEOUT, 4096, maximum RUN cycles to wait for fft_done.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_req  in  1  request one capture/FFT/unload cycle; sampled only in IDLE.
- adc_data  in  DATA_WIDTH  signed sample.
- adc_valid  in  1  sample qualifier; gaps allowed.
- ld_wen  out  1  RAM write enable (load).
- ld_waddr  out  ADDR_WIDTH  RAM write address (bit-reversed sample index).
- ld_wdata  out  2*DATA_WIDTH  {DATA_WIDTH'd0, adc_data}.
- ram_sel  out  1  0 = this block owns RAM ports, 1 = FFT engine owns them.
- fft_start  out  1  one-cycle start pulse to the engine.
- fft_done  in  1  one-cycle done pulse from the engine.
- rd_ren  out  1  RAM read enable (unload).
- rd_raddr  out  ADDR_WIDTH  RAM read address.
- rd_rdata  in  2*DATA_WIDTH  RAM read data, valid 1 cycle after rd_ren.
- mag_data  out  DATA_WIDTH+1  unsigned |re|+|im|.
- mag_valid  out  1  mag_data qualifier.
- mag_index  out  ADDR_WIDTH  bin number of mag_data.
- mag_last  out  1  with mag_valid on the final bin.
- busy  out  1  state != IDLE.
- fft_err  out  1  one-cycle pulse on RUN timeout.

## Operation
- States: IDLE, LOAD, START, RUN, UNLOAD, DRAIN.
- IDLE: frame_req=1 -> LOAD, sample counter cleared. frame_req in any other state is ignored (no queuing).
- LOAD: each adc_valid writes ld_wdata to ld_waddr = bitrev(cnt), then cnt++. After the N-th write -> START.
- START: fft_start=1 and ram_sel=1 for one cycle -> RUN.
- RUN: ram_sel=1 and the watchdog counts. fft_done -> UNLOAD. If the watchdog reaches TIMEOUT without fft_done: fft_err pulse, ram_sel=0, -> IDLE.
- UNLOAD: rd_ren=1 every cycle with rd_raddr = 0,1,2,... up to OUT_LEN-1 (OUT_LEN = N/2 if OUT_HALF, else N). After the last address is issued -> DRAIN.
- DRAIN: wait until the last magnitude has been output -> IDLE.
- Magnitude: abs of each signed half, sign-extended to DATA_WIDTH+1, then added. No saturation; -32768 gives 32768 exactly.
- fft_done outside RUN is ignored.
- ld_wen and rd_ren are never high while ram_sel=1.

## Timing
- Reset values: all outputs 0. State is IDLE.
- ld_wen is registered: it is high the cycle after adc_valid is sampled, with the matching address and data.
- fft_start asserts the cycle after the N-th ld_wen.
- ram_sel rises the same cycle as fft_start. It falls the cycle after fft_done is sampled, which is the first UNLOAD cycle.
- Read pipeline: rd_ren at cycle t, rd_rdata at t+1, registered mag_data/mag_valid/mag_index at t+2. There are no bubbles, so OUT_LEN mag_valid cycles are consecutive.
- busy falls the cycle after mag_last.
- Watchdog clears on entry to RUN. fft_err asserts on cycle TIMEOUT of RUN.
- Reset mid-operation: immediate abort. Outputs return to 0, including ram_sel; a partial frame is discarded.

## Test plan
- Reset: hold rst_n=0, then release. All outputs are 0 and busy=0. Asserting rst_n=0 mid-UNLOAD drives mag_valid, rd_ren and busy to 0 immediately.
- Continuous load, ADDR_WIDTH=8, ramp samples 0..255 with adc_valid held high -> ld_waddr sequence 0,128,64,192,32,... and ld_wdata=32'h0000_00xx. fft_start pulses once, the cycle after the 256th write; ram_sel=1 from then on.
- Gapped load, adc_valid every third cycle -> exactly 256 writes with the same address sequence; no writes during gaps.
- Unload: fft_done after 1000 RUN cycles, then RAM model returns {im=-5, re=3} at addr 0 and {-32768,-32768} at addr 1 -> mag_data 8 at index 0 and 65536 at index 1. Bins 0..127 stream consecutively and mag_last is high with index 127.
- Timeout: no fft_done within 4096 cycles -> one fft_err pulse, ram_sel=0, busy=0. A later frame_req restarts with a fresh LOAD.
- Ignored events: frame_req and fft_done pulses during LOAD -> no state change, no fft_start, and the write count is still 256.
